// File: rtl/dmux_stream_nway.sv
// Registered N-way stream demultiplexer: one valid/ready slot per channel,
// unicast or broadcast routing, and a drop counter for out-of-range selects.

module dmux_stream_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         vld;
  logic [W-1:0] slot;

  // Load beats drain, so a slot refilled while being consumed stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      slot <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      slot <= word;
    end else if (ready) begin
      vld  <= 1'b0;
    end
  end

  assign valid = vld;
  assign data  = vld ? slot : '0;
endmodule

module dmux_stream_nway #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int SW = $clog2(N),
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_bcast,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic           sel_err,
  output logic [CW-1:0]  drop_cnt
);
  logic [N-1:0]        free, load;
  logic [N-1:0][W-1:0] lane_data;
  logic                sel_ok, sel_free, acc, bad;

  always_comb begin
    free     = ~out_valid | out_ready;
    sel_ok   = {1'b0, in_sel} < (SW+1)'(N);
    sel_free = 1'b0;
    for (int i = 0; i < N; i++)
      if (in_sel == SW'(i)) sel_free = free[i];
    // A bad select is always accepted so the producer never stalls on it.
    if (in_bcast)    in_ready = &free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;
    acc  = in_valid & in_ready;
    bad  = acc & ~in_bcast & ~sel_ok;
    load = '0;
    for (int i = 0; i < N; i++)
      load[i] = acc & (in_bcast | (sel_ok & (in_sel == SW'(i))));
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    dmux_stream_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .word  (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .data  (lane_data[i])
    );
  end

  assign out_data = lane_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_err <= bad;
      if (bad && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmux_stream_nway.sv
// Bench for dmux_stream_nway: walking-select table, hand-written corner
// sequences, a 6-channel bad-select instance and a randomized model check.

module tb_dmux_stream_nway;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 8-channel instance
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic         in_bcast, in_valid, in_ready, sel_err;
  logic [127:0] out_data;
  logic [7:0]   out_valid, out_ready, drop_cnt;

  // 6-channel instance with a 2-bit drop counter
  logic [15:0]  b_data;
  logic [2:0]   b_sel;
  logic         b_bcast, b_valid, b_in_ready, b_sel_err;
  logic [95:0]  b_out_data;
  logic [5:0]   b_out_valid, b_out_ready;
  logic [1:0]   b_drop_cnt;

  dmux_stream_nway #(.W(16), .N(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .drop_cnt(drop_cnt));

  dmux_stream_nway #(.W(16), .N(6), .CW(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel),
    .in_bcast(b_bcast), .in_valid(b_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err), .drop_cnt(b_drop_cnt));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0]  data;
    logic [2:0]   sel;
    logic [7:0]   exp_valid;
    logic [127:0] exp_data;
  } vec_t;

  vec_t tbl[16];

  // Behavioural model: one optional word per channel.
  bit          mv[8];
  logic [15:0] md[8];

  initial begin
    logic [7:0]   ev;
    logic [127:0] ed;
    logic         exp_rdy, acc;
    logic [15:0]  w;

    for (int k = 0; k < 16; k++) begin
      tbl[k].data      = 16'(k / 8);
      tbl[k].sel       = 3'(k % 8);
      tbl[k].exp_valid = 8'd1 << tbl[k].sel;
      tbl[k].exp_data  = 128'(tbl[k].data) << (16 * tbl[k].sel);
    end

    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ready = 8'hFF;
    b_data = '0; b_sel = '0; b_bcast = 1'b0; b_valid = 1'b0; b_out_ready = 6'h3F;
    #3;
    chk("reset_valid", 128'(out_valid), 128'(0));
    chk("reset_data", out_data, 128'(0));
    chk("reset_sel_err", 128'(sel_err), 128'(0));
    chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));
    #9 rst_n = 1'b1;
    tick;

    // Walking select, data 0 then 1, all consumers ready.
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = tbl[k].data; in_sel = tbl[k].sel;
      #1;
      chk("walk_in_ready", 128'(in_ready), 128'(1));
      tick;
      chk($sformatf("walk_valid_%0d", k), 128'(out_valid), 128'(tbl[k].exp_valid));
      chk($sformatf("walk_data_%0d", k), out_data, tbl[k].exp_data);
    end
    in_valid = 1'b0;
    tick;
    chk("walk_drained", 128'(out_valid), 128'(0));

    // Backpressure on channel 3.
    out_ready = 8'hF7; in_valid = 1'b1; in_sel = 3'd3; in_data = 16'hA5A5;
    tick;
    in_data = 16'h1234;
    #1;
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    tick;
    chk("bp_hold_data", 128'(out_data[63:48]), 128'(16'hA5A5));
    chk("bp_hold_valid", 128'(out_valid), 128'(8'h08));
    out_ready = 8'hFF;
    #1;
    chk("bp_in_ready_high", 128'(in_ready), 128'(1));
    tick;
    chk("bp_new_data", 128'(out_data[63:48]), 128'(16'h1234));
    chk("bp_new_valid", 128'(out_valid), 128'(8'h08));
    in_valid = 1'b0;
    tick;

    // Broadcast blocked by full slot 5, then released.
    out_ready = 8'hDF; in_valid = 1'b1; in_sel = 3'd5; in_data = 16'h1111;
    tick;
    in_bcast = 1'b1; in_data = 16'hBEEF; in_sel = 3'd0;
    #1;
    chk("bc_in_ready_low", 128'(in_ready), 128'(0));
    tick;
    chk("bc_stall_valid", 128'(out_valid), 128'(8'h20));
    chk("bc_stall_data", out_data, 128'(16'h1111) << 80);
    out_ready = 8'hFF;
    #1;
    chk("bc_in_ready_high", 128'(in_ready), 128'(1));
    tick;
    chk("bc_all_valid", 128'(out_valid), 128'(8'hFF));
    chk("bc_all_data", out_data, {8{16'hBEEF}});
    in_bcast = 1'b0; in_valid = 1'b0;
    tick;

    // Back-to-back stream to channel 2.
    in_valid = 1'b1; in_sel = 3'd2;
    for (int k = 0; k < 6; k++) begin
      w = 16'hC000 + 16'(k);
      in_data = w;
      #1;
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      tick;
      chk("stream_valid", 128'(out_valid), 128'(8'h04));
      chk("stream_data", out_data, 128'(w) << 32);
    end
    in_valid = 1'b0;
    tick;

    // Bad select on the 6-channel instance.
    b_valid = 1'b1; b_sel = 3'd7; b_data = 16'hDEAD;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("bad_in_ready", 128'(b_in_ready), 128'(1));
      tick;
      chk("bad_sel_err", 128'(b_sel_err), 128'(1));
      chk($sformatf("bad_drop_cnt_%0d", k), 128'(b_drop_cnt), 128'(k > 3 ? 3 : k));
      chk("bad_no_valid", 128'(b_out_valid), 128'(0));
    end
    b_valid = 1'b0;
    tick;
    chk("bad_sel_err_clear", 128'(b_sel_err), 128'(0));
    chk("bad_drop_cnt_hold", 128'(b_drop_cnt), 128'(3));
    chk("bad_main_sel_err", 128'(sel_err), 128'(0));

    // Asynchronous reset while slot 4 is full.
    out_ready = 8'hEF; in_valid = 1'b1; in_sel = 3'd4; in_data = 16'h4444;
    tick;
    in_valid = 1'b0;
    chk("rst_pre_valid", 128'(out_valid), 128'(8'h10));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 128'(out_valid), 128'(0));
    chk("rst_async_data", out_data, 128'(0));
    chk("rst_async_drop6", 128'(b_drop_cnt), 128'(0));
    #2 rst_n = 1'b1;
    tick;
    in_valid = 1'b1; in_data = 16'h4A4A;
    #1;
    chk("rst_after_in_ready", 128'(in_ready), 128'(1));
    tick;
    chk("rst_after_valid", 128'(out_valid), 128'(8'h10));
    chk("rst_after_data", out_data, 128'(16'h4A4A) << 64);
    in_valid = 1'b0; out_ready = 8'hFF;
    tick;

    // Randomized traffic against the model.
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bcast  = ($urandom_range(0, 9) == 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      out_ready = 8'($urandom);
      #1;
      if (in_bcast) begin
        exp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) if (mv[i] && !out_ready[i]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = !mv[in_sel] || out_ready[in_sel];
      end
      chk("rand_in_ready", 128'(in_ready), 128'(exp_rdy));
      acc = in_valid && exp_rdy;
      for (int i = 0; i < 8; i++) begin
        if (acc && (in_bcast || int'(in_sel) == i)) begin
          mv[i] = 1'b1; md[i] = in_data;
        end else if (out_ready[i]) begin
          mv[i] = 1'b0;
        end
      end
      tick;
      ev = '0; ed = '0;
      for (int i = 0; i < 8; i++) begin
        ev[i] = mv[i];
        ed[i*16 +: 16] = mv[i] ? md[i] : 16'h0;
      end
      chk("rand_valid", 128'(out_valid), 128'(ev));
      chk("rand_data", out_data, ed);
      chk("rand_sel_err", 128'(sel_err), 128'(0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
